key_input_conditioner: RTL and testbench

KEY_INPUT_CONDITIONER -- requirements
Module: key_input_conditioner

---
 rtl/key_input_conditioner.sv | 192 +++++++++++++++++++
 tb/tb_key_input_conditioner.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/key_input_conditioner.sv
// Keypad input conditioner: synchronizes and debounces ten digit keys plus '#',
// produces press/release strobes, tracks the code of the last accepted press and,
// when the KEY_REPEAT_EN macro is defined, generates auto-repeat strobes for the
// held key. Without KEY_REPEAT_EN, REPEAT_PULSE is tied low and the repeat
// machinery is not built.
module key_input_conditioner #(
  parameter int unsigned DEBOUNCE_CYCLES = 5000,
  parameter int unsigned REPEAT_DELAY    = 500000,
  parameter int unsigned REPEAT_PERIOD   = 100000
) (
  input  logic        CLK,
  input  logic        rst,
  input  logic [9:0]  KEY,
  input  logic        KEY_HASH,
  output logic [10:0] KEY_STABLE,
  output logic        PRESS_PULSE,
  output logic        RELEASE_PULSE,
  output logic [3:0]  KEY_CODE,
  output logic        ANY_HELD,
  output logic        REPEAT_PULSE
);

  localparam int          NKEYS     = 11;
  localparam logic [3:0]  CODE_NONE = 4'd15;
  localparam logic [15:0] DB_LAST   = 16'(DEBOUNCE_CYCLES - 1);

  logic [NKEYS-1:0] raw;
  logic [NKEYS-1:0] meta_q, sync_q, sample_q;

  logic [15:0]      db_cnt_q [NKEYS];
  logic [15:0]      db_cnt_d [NKEYS];
  logic [NKEYS-1:0] stable_q, stable_d;

  logic [NKEYS-1:0] rise, fall;
  logic [15:0]      fall_ext;
  logic             press_q, press_d;
  logic             release_q, release_d;
  logic [3:0]       code_q, code_d;

  assign raw = {KEY_HASH, KEY};

  // Two-flop synchronizer, then one registered sample that feeds the debouncers.
  // NOTE: every clocked register uses non-blocking assignments so all flops
  // update from the same pre-edge values; blocking here would collapse the chain.
  always_ff @(posedge CLK or posedge rst) begin
    if (rst) begin
      meta_q   <= '0;
      sync_q   <= '0;
      sample_q <= '0;
    end else begin
      meta_q   <= raw;
      sync_q   <= meta_q;
      sample_q <= sync_q;
    end
  end

  // Per-key debounce: count consecutive mismatch cycles, accept on the last one.
  // NOTE: combinational blocks assign a default to every output first, so no
  // path leaves a signal unassigned and no latch is inferred.
  always_comb begin
    stable_d = stable_q;
    for (int i = 0; i < NKEYS; i++) begin
      db_cnt_d[i] = '0;
      if (sample_q[i] != stable_q[i]) begin
        if (db_cnt_q[i] >= DB_LAST) begin
          stable_d[i] = sample_q[i];
        end else begin
          db_cnt_d[i] = db_cnt_q[i] + 16'd1;
        end
      end
    end
  end

  // Debounce counters and accepted levels.
  // NOTE: the counter array is a register bank, not a RAM, and must clear on
  // reset so a partial count never survives into the next press.
  always_ff @(posedge CLK or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NKEYS; i++) db_cnt_q[i] <= '0;
      stable_q <= '0;
    end else begin
      for (int i = 0; i < NKEYS; i++) db_cnt_q[i] <= db_cnt_d[i];
      stable_q <= stable_d;
    end
  end

  // Edge detection on the accepted levels; strobes are registered so they line
  // up with the cycle in which KEY_STABLE changes. Digit 0 wins ties.
  always_comb begin
    rise      = stable_d & ~stable_q;
    fall      = stable_q & ~stable_d;
    fall_ext  = {5'b0, fall};
    press_d   = |rise;
    release_d = fall_ext[code_q];
    code_d    = code_q;
    for (int i = NKEYS - 1; i >= 0; i--) begin
      if (rise[i]) code_d = 4'(i);
    end
  end

  // Strobe and key-code registers.
  always_ff @(posedge CLK or posedge rst) begin
    if (rst) begin
      press_q   <= 1'b0;
      release_q <= 1'b0;
      code_q    <= CODE_NONE;
    end else begin
      press_q   <= press_d;
      release_q <= release_d;
      code_q    <= code_d;
    end
  end

  assign KEY_STABLE    = stable_q;
  assign PRESS_PULSE   = press_q;
  assign RELEASE_PULSE = release_q;
  assign KEY_CODE      = code_q;
  assign ANY_HELD      = |stable_q;

`ifdef KEY_REPEAT_EN
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DELAY  = 2'd1,
    REPEAT = 2'd2
  } rpt_state_e;

  localparam logic [19:0] DELAY_LAST  = 20'(REPEAT_DELAY - 1);
  localparam logic [19:0] PERIOD_LAST = 20'(REPEAT_PERIOD - 1);

  rpt_state_e  state_q, state_d;
  logic [19:0] rpt_cnt_q, rpt_cnt_d;
  logic        repeat_fire;

  // Repeat FSM next state: a new press restarts the delay, a release of the
  // tracked key returns to IDLE, and neither cycle emits a repeat strobe.
  always_comb begin
    state_d     = state_q;
    rpt_cnt_d   = rpt_cnt_q;
    repeat_fire = 1'b0;
    if (press_q) begin
      state_d   = DELAY;
      rpt_cnt_d = '0;
    end else if (release_q) begin
      state_d   = IDLE;
      rpt_cnt_d = '0;
    end else begin
      case (state_q)
        IDLE: begin
          rpt_cnt_d = '0;
        end
        DELAY: begin
          if (rpt_cnt_q >= DELAY_LAST) begin
            repeat_fire = 1'b1;
            state_d     = REPEAT;
            rpt_cnt_d   = '0;
          end else begin
            rpt_cnt_d = rpt_cnt_q + 20'd1;
          end
        end
        REPEAT: begin
          if (rpt_cnt_q >= PERIOD_LAST) begin
            repeat_fire = 1'b1;
            rpt_cnt_d   = '0;
          end else begin
            rpt_cnt_d = rpt_cnt_q + 20'd1;
          end
        end
        default: begin
          state_d   = IDLE;
          rpt_cnt_d = '0;
        end
      endcase
    end
  end

  // Repeat FSM state and counter registers.
  always_ff @(posedge CLK or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      rpt_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      rpt_cnt_q <= rpt_cnt_d;
    end
  end

  assign REPEAT_PULSE = repeat_fire;
`else
  assign REPEAT_PULSE = 1'b0;
`endif

endmodule

// File: tb/tb_key_input_conditioner.sv
// Self-checking bench for key_input_conditioner (DEBOUNCE_CYCLES=4,
// REPEAT_DELAY=10, REPEAT_PERIOD=5). A window-based reference model predicts
// every output each cycle; directed sequences pin exact cycle timings.
module tb_key_input_conditioner;

  localparam int D  = 4;
  localparam int RD = 10;
  localparam int RP = 5;

  logic        CLK = 1'b0;
  logic        rst = 1'b0;
  logic [9:0]  KEY = '0;
  logic        KEY_HASH = 1'b0;
  logic [10:0] KEY_STABLE;
  logic        PRESS_PULSE, RELEASE_PULSE, ANY_HELD, REPEAT_PULSE;
  logic [3:0]  KEY_CODE;

  int n_checks = 0;
  int n_errors = 0;
  int n_press = 0, n_release = 0, n_repeat = 0;
  bit cmp_en = 1'b0;

  key_input_conditioner #(
    .DEBOUNCE_CYCLES(D),
    .REPEAT_DELAY   (RD),
    .REPEAT_PERIOD  (RP)
  ) dut (
    .CLK          (CLK),
    .rst          (rst),
    .KEY          (KEY),
    .KEY_HASH     (KEY_HASH),
    .KEY_STABLE   (KEY_STABLE),
    .PRESS_PULSE  (PRESS_PULSE),
    .RELEASE_PULSE(RELEASE_PULSE),
    .KEY_CODE     (KEY_CODE),
    .ANY_HELD     (ANY_HELD),
    .REPEAT_PULSE (REPEAT_PULSE)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // hist[j] is the raw level sampled j edges ago. A key flips when the D samples
  // that have reached the comparator all disagree with its accepted level.
  logic [10:0] hist [0:D+2];
  logic [10:0] m_stable;
  logic        m_press, m_release, m_repeat;
  logic [3:0]  m_code;
  bit          m_active;
  int          m_age;

  always @(posedge CLK or posedge rst) begin
    if (rst) begin
      for (int j = 0; j <= D + 2; j++) hist[j] = '0;
      m_stable = '0; m_press = 0; m_release = 0; m_repeat = 0;
      m_code = 4'd15; m_active = 0; m_age = 0;
    end else begin
      logic [10:0] nxt, rise, fall;
      int idx;
      for (int j = D + 2; j > 0; j--) hist[j] = hist[j-1];
      hist[0] = {KEY_HASH, KEY};
      nxt = m_stable;
      for (int i = 0; i < 11; i++) begin
        bit all_diff;
        all_diff = 1;
        for (int j = 3; j <= D + 2; j++) if (hist[j][i] == m_stable[i]) all_diff = 0;
        if (all_diff) nxt[i] = ~m_stable[i];
      end
      rise = nxt & ~m_stable;
      fall = m_stable & ~nxt;
      idx = int'(m_code);
      m_release = (idx < 11) ? fall[idx] : 1'b0;
      m_press = |rise;
      for (int i = 10; i >= 0; i--) if (rise[i]) m_code = 4'(i);
      m_stable = nxt;
      if (m_press) begin m_active = 1; m_age = 0; end
      else if (m_release) m_active = 0;
      else if (m_active) m_age++;
`ifdef KEY_REPEAT_EN
      m_repeat = m_active && !m_press && !m_release && m_age >= RD && ((m_age - RD) % RP == 0);
`else
      m_repeat = 0;
`endif
    end
  end

  // Compare process and strobe counters, sampled well after the active edge.
  always @(posedge CLK) begin
    #2;
    n_press   += int'(PRESS_PULSE);
    n_release += int'(RELEASE_PULSE);
    n_repeat  += int'(REPEAT_PULSE);
    if (cmp_en) begin
      check("model_key_stable", 32'(KEY_STABLE), 32'(m_stable));
      check("model_press", 32'(PRESS_PULSE), 32'(m_press));
      check("model_release", 32'(RELEASE_PULSE), 32'(m_release));
      check("model_key_code", 32'(KEY_CODE), 32'(m_code));
      check("model_any_held", 32'(ANY_HELD), 32'(|m_stable));
      check("model_repeat", 32'(REPEAT_PULSE), 32'(m_repeat));
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic step(input int n);
    repeat (n) @(negedge CLK);
  endtask

  task automatic wait_press(input string name);
    bit found;
    found = 0;
    for (int c = 0; c < 40 && !found; c++) begin
      @(posedge CLK); #1;
      if (PRESS_PULSE) found = 1;
    end
    check(name, 32'(found), 32'd1);
  endtask

  initial begin
    logic [31:0] mask, exp_mask;
    int p0, r0, q0;
    bit found;

`ifdef KEY_REPEAT_EN
    exp_mask = 32'h4210_8400;
`else
    exp_mask = 32'h0;
`endif

    // Reset state
    #1 rst = 1'b1;
    cmp_en = 1'b1;
    step(3);
    check("rst_key_code", 32'(KEY_CODE), 32'd15);
    check("rst_key_stable", 32'(KEY_STABLE), 32'd0);
    check("rst_strobes", {29'd0, PRESS_PULSE, RELEASE_PULSE, REPEAT_PULSE}, 32'd0);
    check("rst_any_held", 32'(ANY_HELD), 32'd0);
    rst = 1'b0;
    step(10);

    // Clean press of KEY[3]: accepted at edge 6
    KEY[3] = 1'b1;
    repeat (6) @(posedge CLK); #1;
    check("press3_edge5_stable", 32'(KEY_STABLE), 32'd0);
    @(posedge CLK); #1;
    check("press3_edge6_stable", 32'(KEY_STABLE), 32'h008);
    check("press3_edge6_pulse", 32'(PRESS_PULSE), 32'd1);
    check("press3_edge6_code", 32'(KEY_CODE), 32'd3);
    check("press3_edge6_any", 32'(ANY_HELD), 32'd1);
    @(posedge CLK); #1;
    check("press3_one_cycle", 32'(PRESS_PULSE), 32'd0);
    @(negedge CLK); KEY[3] = 1'b0;
    step(12);
    check("press3_code_holds", 32'(KEY_CODE), 32'd3);

    // Glitches shorter than the debounce window
    p0 = n_press; r0 = n_release;
    KEY[5] = 1'b1; step(3); KEY[5] = 1'b0; step(3);
    KEY[5] = 1'b1; step(2); KEY[5] = 1'b0; step(1);
    KEY[5] = 1'b1; step(2); KEY[5] = 1'b0; step(12);
    check("glitch_stable", 32'(KEY_STABLE), 32'd0);
    check("glitch_no_press", 32'(n_press - p0), 32'd0);
    check("glitch_no_release", 32'(n_release - r0), 32'd0);

    // Pulse of exactly D cycles is accepted
    p0 = n_press;
    KEY[4] = 1'b1; step(D); KEY[4] = 1'b0; step(14);
    check("pulse_d_accepted", 32'(n_press - p0), 32'd1);

    // Simultaneous KEY[7] and '#'
    p0 = n_press;
    KEY[7] = 1'b1; KEY_HASH = 1'b1;
    wait_press("dual_press_seen");
    check("dual_code", 32'(KEY_CODE), 32'd7);
    check("dual_stable", 32'(KEY_STABLE), 32'h480);
    @(negedge CLK);
    check("dual_single_press", 32'(n_press - p0), 32'd1);
    r0 = n_release;
    KEY_HASH = 1'b0; step(12);
    check("hash_release_silent", 32'(n_release - r0), 32'd0);
    check("hash_released_stable", 32'(KEY_STABLE), 32'h080);
    KEY[7] = 1'b0; step(12);
    check("key7_release_pulse", 32'(n_release - r0), 32'd1);
    check("key7_code_holds", 32'(KEY_CODE), 32'd7);

    // Auto-repeat on KEY[1]
    KEY[1] = 1'b1;
    wait_press("rpt_press_seen");
    check("rpt_code", 32'(KEY_CODE), 32'd1);
    mask = '0;
    for (int off = 1; off <= 30; off++) begin
      @(posedge CLK); #1;
      mask[off] = REPEAT_PULSE;
    end
    check("rpt_offsets", mask, exp_mask);
    @(negedge CLK); KEY[1] = 1'b0;
    found = 0;
    for (int c = 0; c < 20 && !found; c++) begin
      @(posedge CLK); #1;
      if (RELEASE_PULSE) found = 1;
    end
    check("rpt_release_seen", 32'(found), 32'd1);
    q0 = n_repeat;
    step(20);
    check("rpt_idle_after_release", 32'(n_repeat - q0), 32'd0);

    // Reset mid-delay while KEY[2] held
    KEY[2] = 1'b1;
    wait_press("rst_press_seen");
    step(4);
    rst = 1'b1; #1;
    check("midrst_code", 32'(KEY_CODE), 32'd15);
    check("midrst_stable", 32'(KEY_STABLE), 32'd0);
    check("midrst_repeat", 32'(REPEAT_PULSE), 32'd0);
    step(2);
    rst = 1'b0;
    repeat (6) @(posedge CLK); #1;
    check("rerelease_edge5", 32'(PRESS_PULSE), 32'd0);
    @(posedge CLK); #1;
    check("repress_edge6", 32'(PRESS_PULSE), 32'd1);
    check("repress_code", 32'(KEY_CODE), 32'd2);
    @(negedge CLK); KEY[2] = 1'b0;
    step(12);

    // Randomized bouncing traffic with occasional resets
    for (int seg = 0; seg < 200; seg++) begin
      logic [10:0] tgt, drv;
      int r, len, b;
      r = $urandom_range(0, 9);
      if (r < 4) tgt = '0;
      else if (r < 8) tgt = 11'(1) << $urandom_range(0, 10);
      else tgt = (11'(1) << $urandom_range(0, 10)) | (11'(1) << $urandom_range(0, 10));
      len = ($urandom_range(0, 7) == 0) ? 45 : int'($urandom_range(1, 14));
      if ($urandom_range(0, 29) == 0) begin
        @(negedge CLK); rst = 1'b1;
        step(2);
        rst = 1'b0;
      end
      for (int c = 0; c < len; c++) begin
        @(negedge CLK);
        drv = tgt;
        if ($urandom_range(0, 5) == 0) begin
          b = $urandom_range(0, 10);
          drv[b] = ~drv[b];
        end
        {KEY_HASH, KEY} = drv;
      end
    end
    @(negedge CLK); {KEY_HASH, KEY} = '0;
    step(20);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
